// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store sequencer: access sizes, FSM states,
// the latched request-control payload and the data width.
package mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [SIZE_W-1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        ST_WR,
        LD_RD,
        LD_RSP,
        RMW_RD,
        RMW_WR,
        ERR
    } state_e;

    // Access formatting controls captured at the accept edge.
    typedef struct packed {
        size_e size;
        logic  sext;
    } req_ctl_t;

    // Byte and halfword stores need a read-modify-write; word and reserved do not.
    function automatic logic is_subword(input size_e size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatter: load lane extract + zero/sign extend, and store lane merge
// into the word read back from memory.
module mem_lane_fmt
    import mem_pkg::*;
(
    input  size_e             size,
    input  logic              sext,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] rd,
    input  logic [15:0]       wdata,
    output logic [DATA_W-1:0] ld_data_c,
    output logic [DATA_W-1:0] st_data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Little-endian lanes: byte k at bits [8k+7:8k], half h at bits [16h+15:16h].
    always_comb begin
        byte_c    = rd[{lane, 3'b000} +: 8];
        half_c    = rd[{lane[1], 4'b0000} +: 16];
        ld_data_c = rd;
        st_data_c = rd;
        case (size)
            SZ_BYTE: begin
                ld_data_c = {{(DATA_W-8){sext & byte_c[7]}}, byte_c};
                st_data_c[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                ld_data_c = {{(DATA_W-16){sext & half_c[15]}}, half_c};
                st_data_c[{lane[1], 4'b0000} +: 16] = wdata;
            end
            default: begin
                ld_data_c = rd;
                st_data_c = rd;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer driving a registered-read data memory.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests go to ERR and pulse err.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned TAG_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              stall,
    output logic              err,
    output logic              dm_we,
    output logic              dm_re,
    output logic [31:0]       dm_addr,
    output logic [31:0]       dm_wd,
    input  logic [31:0]       dm_rd
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned AQ_W  = IDX_W + 2;

    state_e            state;
    state_e            state_nxt;
    req_ctl_t          ctl_q;
    logic [AQ_W-1:0]   addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [TAG_W-1:0]  tag_q;
    logic              accept_c;
    logic              misalign_c;
    logic              err_c;
    logic [DATA_W-1:0] ld_data_c;
    logic [DATA_W-1:0] st_data_c;
    logic              addr_hi_unused;

    // Address bits above the word index wrap away silently.
    assign addr_hi_unused = ^req_addr[DATA_W-1:AQ_W];

    assign req_ready = (state == IDLE) && !rst;
    assign accept_c  = req_valid && req_ready;
    assign stall     = req_valid && !req_ready;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign_c = 1'b0;
        case (size_e'(req_size))
            SZ_BYTE:          misalign_c = 1'b0;
            SZ_HALF:          misalign_c = req_addr[0];
            SZ_WORD, SZ_RSVD: misalign_c = |req_addr[1:0];
            default:          misalign_c = 1'b0;
        endcase
    end
    assign err = err_c;
`else
    assign misalign_c = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request fields are captured only at the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tag_q   <= '0;
        end else if (accept_c) begin
            ctl_q.size <= size_e'(req_size);
            ctl_q.sext <= req_signed;
            addr_q     <= req_addr[AQ_W-1:0];
            wdata_q    <= req_wdata;
            tag_q      <= req_tag;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (misalign_c) begin
                        state_nxt = ERR;
                    end else if (!req_we) begin
                        state_nxt = LD_RD;
                    end else if (is_subword(size_e'(req_size))) begin
                        state_nxt = RMW_RD;
                    end else begin
                        state_nxt = ST_WR;
                    end
                end
            end
            LD_RD:                       state_nxt = LD_RSP;
            RMW_RD:                      state_nxt = RMW_WR;
            ST_WR, LD_RSP, RMW_WR, ERR:  state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // Strobes are gated by rst so nothing is written or returned in a reset cycle.
    always_comb begin
        dm_we      = 1'b0;
        dm_re      = 1'b0;
        resp_valid = 1'b0;
        err_c      = 1'b0;
        dm_wd      = '0;
        resp_rdata = '0;
        case (state)
            ST_WR, RMW_WR: dm_we      = !rst;
            LD_RD, RMW_RD: dm_re      = !rst;
            LD_RSP:        resp_valid = !rst;
            ERR:           err_c      = !rst;
            default:       dm_we      = 1'b0;
        endcase
        if (dm_we) begin
            dm_wd = (state == ST_WR) ? wdata_q : st_data_c;
        end
        if (resp_valid) begin
            resp_rdata = ld_data_c;
        end
    end

    assign dm_addr  = DATA_W'({addr_q[AQ_W-1:2], 2'b00});
    assign resp_tag = tag_q;

    mem_lane_fmt u_lane_fmt (
        .size      (ctl_q.size),
        .sext      (ctl_q.sext),
        .lane      (addr_q[1:0]),
        .rd        (dm_rd),
        .wdata     (wdata_q[15:0]),
        .ld_data_c (ld_data_c),
        .st_data_c (st_data_c)
    );

endmodule
